// File: rtl/arbitro_memoria_instrucoes_pkg.sv
// Shared processor definitions: arbiter states and instruction opcode fields.
package pkg_processador;

    typedef enum logic [1:0] {
        CARGA    = 2'd0,
        EXECUCAO = 2'd1,
        PARADO   = 2'd2
    } estado_arbitro_t;

    localparam int unsigned LARGURA_OPCODE = 5;
    localparam int unsigned OPC_MSB        = 31;
    localparam int unsigned OPC_LSB        = 27;

    localparam logic [LARGURA_OPCODE-1:0] OPC_HALT      = 5'd18;
    localparam logic [31:0]               OPC_NOP_INSTR = 32'd0;

    function automatic logic [LARGURA_OPCODE-1:0] opcode_de(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/arbitro_memoria_instrucoes_contador_carga.sv
// Load write pointer: restarts at the entry address, counts accepted words,
// and saturates at the physical memory depth.
module contador_carga #(
    parameter int unsigned AW           = 10,
    parameter int unsigned PROFUNDIDADE = 41,
    parameter int unsigned END_INICIAL  = 1
) (
    input  logic          clock,
    input  logic          i_carrega,
    input  logic          i_incrementa,
    output logic [AW-1:0] o_ptr,
    output logic          o_cheio
);

    logic [AW-1:0] r_ptr;
    logic          w_cheio;

    assign w_cheio = (r_ptr >= AW'(PROFUNDIDADE));

    always_ff @(posedge clock) begin
        if (i_carrega) begin
            r_ptr <= AW'(END_INICIAL);
        end else if (i_incrementa && !w_cheio) begin
            r_ptr <= r_ptr + AW'(1);
        end
    end

    assign o_ptr   = r_ptr;
    assign o_cheio = w_cheio;

endmodule

// File: rtl/arbitro_memoria_instrucoes.sv
// Owns the instruction memory port: boot-load, CPU execution and halted phases,
// holding the CPU off until a complete program has been written.
module arbitro_memoria_instrucoes
    import pkg_processador::*;
#(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned AW           = 10,
    parameter int unsigned PROFUNDIDADE = 41,
    parameter int unsigned END_INICIAL  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carga_valido,
    input  logic [LARGURA-1:0] carga_dado,
    input  logic               carga_fim,
    output logic               carga_pronto,
    input  logic               recarga,
    input  logic [LARGURA-1:0] cpu_endereco,
    input  logic               cpu_busca,
    output logic [LARGURA-1:0] cpu_instrucao,
    output logic               cpu_habilita,
    output logic               parado,
    output logic               erro,
    output logic [AW-1:0]      palavras,
    output logic [AW-1:0]      mem_endereco,
    output logic [LARGURA-1:0] mem_dado,
    output logic               mem_escrita,
    input  logic [LARGURA-1:0] mem_instrucao
);

    localparam int unsigned AW1 = AW + 1;

    estado_arbitro_t r_estado;
    estado_arbitro_t w_proximo;

    logic [AW-1:0]      r_palavras;
    logic               r_erro;
    logic [AW-1:0]      w_ptr;
    logic               w_cheio;
    logic [AW-1:0]      w_end_cpu;
    logic               w_unused_end_alto;
    logic               w_na_faixa;
    logic [LARGURA-1:0] w_instr_exec;
    logic               w_aceita;
    logic               w_overflow;
    logic               w_busca_fora;
    logic               w_halt;

    contador_carga #(
        .AW           (AW),
        .PROFUNDIDADE (PROFUNDIDADE),
        .END_INICIAL  (END_INICIAL)
    ) u_contador (
        .clock        (clock),
        .i_carrega    (reset || recarga),
        .i_incrementa (w_aceita),
        .o_ptr        (w_ptr),
        .o_cheio      (w_cheio)
    );

    // High PC bits do not address this memory.
    assign w_end_cpu         = cpu_endereco[AW-1:0];
    assign w_unused_end_alto = ^cpu_endereco[LARGURA-1:AW];

    assign w_na_faixa   = ({1'b0, w_end_cpu} >= AW1'(END_INICIAL)) &&
                          ({1'b0, w_end_cpu} <  AW1'(END_INICIAL) + {1'b0, r_palavras});
    assign w_instr_exec = w_na_faixa ? mem_instrucao : LARGURA'(OPC_NOP_INSTR);

    assign w_aceita     = carga_valido && carga_pronto;
    assign w_overflow   = w_aceita && !carga_fim && (w_ptr == AW'(PROFUNDIDADE - 1));
    assign w_busca_fora = (r_estado == EXECUCAO) && cpu_busca && !w_na_faixa;
    assign w_halt       = (r_estado == EXECUCAO) && cpu_busca &&
                          (opcode_de(w_instr_exec) == OPC_HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= CARGA;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // recarga overrides any transition, including a HALT fetched the same cycle.
    always_comb begin
        w_proximo = r_estado;
        if (recarga) begin
            w_proximo = CARGA;
        end else begin
            case (r_estado)
                CARGA:    if (w_aceita && carga_fim) w_proximo = EXECUCAO;
                EXECUCAO: if (w_halt) w_proximo = PARADO;
                PARADO:   w_proximo = PARADO;
                default:  w_proximo = CARGA;
            endcase
        end
    end

    always_comb begin
        carga_pronto  = 1'b0;
        cpu_instrucao = LARGURA'(OPC_NOP_INSTR);
        cpu_habilita  = 1'b0;
        parado        = 1'b0;
        mem_endereco  = '0;
        mem_dado      = '0;
        mem_escrita   = 1'b0;
        case (r_estado)
            CARGA: begin
                carga_pronto = !w_cheio && !recarga && !reset;
                mem_endereco = w_ptr;
                mem_dado     = carga_dado;
                mem_escrita  = carga_valido && !w_cheio && !recarga && !reset;
            end
            EXECUCAO: begin
                cpu_habilita  = 1'b1;
                mem_endereco  = w_end_cpu;
                cpu_instrucao = w_instr_exec;
            end
            PARADO: begin
                parado = 1'b1;
            end
            default: begin
                carga_pronto = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_palavras <= '0;
        end else if (w_aceita && carga_fim) begin
            r_palavras <= w_ptr + AW'(1) - AW'(END_INICIAL);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || recarga) begin
            r_erro <= 1'b0;
        end else if (w_overflow || w_busca_fora) begin
            r_erro <= 1'b1;
        end
    end

    assign palavras = r_palavras;
    assign erro     = r_erro;

endmodule

// File: tb/tb_arbitro_memoria_instrucoes.sv
// Directed bench for the instruction-memory arbiter with a behavioural memory.
module tb_arbitro_memoria_instrucoes;

    localparam int unsigned LARGURA = 32;
    localparam int unsigned AW      = 10;
    localparam int unsigned PROF    = 41;

    logic               clock = 1'b0;
    logic               reset;
    logic               carga_valido;
    logic [LARGURA-1:0] carga_dado;
    logic               carga_fim;
    logic               carga_pronto;
    logic               recarga;
    logic [LARGURA-1:0] cpu_endereco;
    logic               cpu_busca;
    logic [LARGURA-1:0] cpu_instrucao;
    logic               cpu_habilita;
    logic               parado;
    logic               erro;
    logic [AW-1:0]      palavras;
    logic [AW-1:0]      mem_endereco;
    logic [LARGURA-1:0] mem_dado;
    logic               mem_escrita;
    logic [LARGURA-1:0] mem_instrucao;

    logic [31:0] r_mem [0:PROF-1] = '{default: '0};
    int          n_escritas = 0;
    int          n_checks = 0;
    int          n_erros  = 0;
    int          base_escritas;

    arbitro_memoria_instrucoes dut (
        .clock         (clock),
        .reset         (reset),
        .carga_valido  (carga_valido),
        .carga_dado    (carga_dado),
        .carga_fim     (carga_fim),
        .carga_pronto  (carga_pronto),
        .recarga       (recarga),
        .cpu_endereco  (cpu_endereco),
        .cpu_busca     (cpu_busca),
        .cpu_instrucao (cpu_instrucao),
        .cpu_habilita  (cpu_habilita),
        .parado        (parado),
        .erro          (erro),
        .palavras      (palavras),
        .mem_endereco  (mem_endereco),
        .mem_dado      (mem_dado),
        .mem_escrita   (mem_escrita),
        .mem_instrucao (mem_instrucao)
    );

    always #5 clock = ~clock;

    // Memory: synchronous write, asynchronous read.
    always @(posedge clock) begin
        if (mem_escrita && (mem_endereco < AW'(PROF))) begin
            r_mem[mem_endereco] <= mem_dado;
            n_escritas <= n_escritas + 1;
        end
    end
    assign mem_instrucao = (mem_endereco < AW'(PROF)) ? r_mem[mem_endereco] : 32'd0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: obtido=0x%08h esperado=0x%08h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic carrega(input logic [31:0] dado, input logic fim);
        carga_valido = 1'b1;
        carga_dado   = dado;
        carga_fim    = fim;
        ciclo();
        carga_valido = 1'b0;
        carga_fim    = 1'b0;
    endtask

    task automatic busca(input logic [31:0] ender, input logic b);
        cpu_endereco = ender;
        cpu_busca    = b;
        #1;
    endtask

    logic [31:0] prog3 [0:2];
    logic [31:0] prog5 [0:4];

    initial begin
        prog3 = '{32'h8000_0019, 32'hC840_0000, 32'h9000_0000};
        prog5 = '{32'h0800_0001, 32'h1000_0002, 32'h1800_0003, 32'h2000_0004, 32'h9000_0005};
        reset = 1'b1; carga_valido = 1'b0; carga_dado = '0; carga_fim = 1'b0;
        recarga = 1'b0; cpu_endereco = '0; cpu_busca = 1'b0;
        ciclo();
        reset = 1'b0;
        #1;
        verifica("rst_habilita", 32'(cpu_habilita), 32'd0);
        verifica("rst_pronto", 32'(carga_pronto), 32'd1);
        verifica("rst_escrita", 32'(mem_escrita), 32'd0);
        verifica("rst_palavras", 32'(palavras), 32'd0);
        verifica("rst_erro", 32'(erro), 32'd0);
        verifica("rst_parado", 32'(parado), 32'd0);
        verifica("rst_endereco", 32'(mem_endereco), 32'd1);

        // Three-word program
        for (int i = 0; i < 3; i++) begin
            carga_valido = 1'b1; carga_dado = prog3[i]; carga_fim = (i == 2);
            #1;
            verifica("c3_endereco", 32'(mem_endereco), 32'(i + 1));
            verifica("c3_escrita", 32'(mem_escrita), 32'd1);
            verifica("c3_habilita", 32'(cpu_habilita), 32'd0);
            ciclo();
        end
        carga_valido = 1'b0; carga_fim = 1'b0;
        #1;
        verifica("c3_habilita_apos", 32'(cpu_habilita), 32'd1);
        verifica("c3_palavras", 32'(palavras), 32'd3);
        verifica("c3_pronto_exec", 32'(carga_pronto), 32'd0);
        for (int i = 0; i < 3; i++) verifica("c3_mem", r_mem[i + 1], prog3[i]);

        // Fetches, including range boundaries and ignored high PC bits
        busca(32'd2, 1'b1);
        verifica("f_end2", cpu_instrucao, 32'hC840_0000);
        busca(32'hFFFF_FC02, 1'b0);
        verifica("f_end2_alto", cpu_instrucao, 32'hC840_0000);
        busca(32'd1, 1'b0);
        verifica("f_end1", cpu_instrucao, 32'h8000_0019);
        busca(32'd0, 1'b0);
        verifica("f_end0", cpu_instrucao, 32'd0);
        busca(32'd4, 1'b0);
        verifica("f_end4", cpu_instrucao, 32'd0);
        ciclo();
        verifica("f_sem_busca_erro", 32'(erro), 32'd0);
        busca(32'd7, 1'b1);
        verifica("f_end7", cpu_instrucao, 32'd0);
        ciclo();
        verifica("f_end7_erro", 32'(erro), 32'd1);
        verifica("f_end7_habilita", 32'(cpu_habilita), 32'd1);
        busca(32'd3, 1'b1);
        verifica("f_halt_instr", cpu_instrucao, 32'h9000_0000);
        ciclo();
        cpu_busca = 1'b0;
        #1;
        verifica("halt_parado", 32'(parado), 32'd1);
        verifica("halt_habilita", 32'(cpu_habilita), 32'd0);
        verifica("halt_instr", cpu_instrucao, 32'd0);
        verifica("halt_escrita", 32'(mem_escrita), 32'd0);

        recarga = 1'b1;
        ciclo();
        recarga = 1'b0;
        #1;
        verifica("rec_erro", 32'(erro), 32'd0);
        verifica("rec_parado", 32'(parado), 32'd0);
        verifica("rec_pronto", 32'(carga_pronto), 32'd1);
        verifica("rec_endereco", 32'(mem_endereco), 32'd1);

        // Overflow: 41 words offered, no end marker
        base_escritas = n_escritas;
        for (int i = 0; i < 41; i++) begin
            carga_valido = 1'b1; carga_dado = 32'h1000 + 32'(i); carga_fim = 1'b0;
            #1;
            verifica("ovf_pronto", 32'(carga_pronto), (i < 40) ? 32'd1 : 32'd0);
            ciclo();
        end
        verifica("ovf_erro", 32'(erro), 32'd1);
        verifica("ovf_escrita", 32'(mem_escrita), 32'd0);
        verifica("ovf_habilita", 32'(cpu_habilita), 32'd0);
        ciclo();
        carga_valido = 1'b0;
        verifica("ovf_n_escritas", 32'(n_escritas - base_escritas), 32'd40);
        verifica("ovf_mem1", r_mem[1], 32'h1000);
        verifica("ovf_mem40", r_mem[40], 32'h1027);

        // recarga together with a valid word: the word is dropped
        recarga = 1'b1; carga_valido = 1'b1; carga_dado = 32'hDEAD_0001;
        #1;
        verifica("rv_pronto", 32'(carga_pronto), 32'd0);
        verifica("rv_escrita", 32'(mem_escrita), 32'd0);
        ciclo();
        recarga = 1'b0; carga_valido = 1'b0;
        #1;
        verifica("rv_mem1", r_mem[1], 32'h1000);
        verifica("rv_erro", 32'(erro), 32'd0);
        verifica("rv_endereco", 32'(mem_endereco), 32'd1);

        // Reset mid-load after two words
        carrega(32'hA1, 1'b0);
        carrega(32'hA2, 1'b0);
        reset = 1'b1; carga_valido = 1'b1; carga_dado = 32'hBBBB;
        #1;
        verifica("rm_escrita", 32'(mem_escrita), 32'd0);
        ciclo();
        reset = 1'b0; carga_valido = 1'b0;
        #1;
        verifica("rm_mem2", r_mem[2], 32'hA2);
        verifica("rm_mem3", r_mem[3], 32'h1002);
        verifica("rm_endereco", 32'(mem_endereco), 32'd1);

        // New five-word program overwrites from address 1
        for (int i = 0; i < 5; i++) carrega(prog5[i], i == 4);
        #1;
        verifica("c5_palavras", 32'(palavras), 32'd5);
        verifica("c5_habilita", 32'(cpu_habilita), 32'd1);
        verifica("c5_mem1", r_mem[1], 32'h0800_0001);
        busca(32'd4, 1'b1);
        verifica("c5_end4", cpu_instrucao, 32'h2000_0004);
        busca(32'd6, 1'b0);
        verifica("c5_end6", cpu_instrucao, 32'd0);
        busca(32'd5, 1'b1);
        verifica("c5_end5", cpu_instrucao, 32'h9000_0005);
        recarga = 1'b1;
        ciclo();
        recarga = 1'b0; cpu_busca = 1'b0;
        #1;
        verifica("rh_parado", 32'(parado), 32'd0);
        verifica("rh_habilita", 32'(cpu_habilita), 32'd0);
        verifica("rh_pronto", 32'(carga_pronto), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria_instrucoes.md
# arbitro_memoria_instrucoes

Sits in front of the 32-bit instruction memory and owns its single address/write port. Sequences the memory through a boot-load phase (a program loader streams instruction words in), an execution phase (the CPU fetch path reads instructions), and a halted phase after the CPU fetches a HALT opcode. Gates the CPU via `cpu_habilita` so the CPU never fetches from a partially written program.

## Interface
- `LARGURA` — 32 — instruction/data word width
- `AW` — 10 — memory address width; matches the memory index `endereco[9:0]`
- `PROFUNDIDADE` — 41 — number of words physically present in the memory
- `END_INICIAL` — 1 — address of the first loaded word; the CPU entry point
- `clock` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `carga_valido` in 1 — loader word valid
- `carga_dado` in 32 — loader instruction word
- `carga_fim` in 1 — qualifies `carga_dado` as the last word of the program
- `carga_pronto` out 1 — arbiter accepts a loader word this cycle
- `recarga` in 1 — single-cycle request to start a new load
- `cpu_endereco` in 32 — CPU fetch address (PC)
- `cpu_busca` in 1 — CPU fetch strobe
- `cpu_instrucao` out 32 — instruction returned to the CPU
- `cpu_habilita` out 1 — CPU may advance
- `parado` out 1 — HALT has been executed
- `erro` out 1 — sticky fault: load overflow or fetch out of range
- `palavras` out AW — number of words in the last completed load
- `mem_endereco` out AW — to memory
- `mem_dado` out 32 — to memory write data
- `mem_escrita` out 1 — memory write enable (memory writes on the rising edge)
- `mem_instrucao` in 32 — memory read data (asynchronous read)

## Operation
- States: CARGA, EXECUCAO, PARADO. Reset sets the state to CARGA.
- **CARGA**
  - `cpu_habilita`=0.
  - `carga_pronto`=1 while `ptr` < `PROFUNDIDADE`.
  - `mem_endereco`=`ptr`, `mem_dado`=`carga_dado`, `mem_escrita`=`carga_valido`&`carga_pronto`.
  - On an accepted word: `ptr`++.
  - If the accepted word has `carga_fim`=1: `palavras` ← `ptr`+1−`END_INICIAL`, and the state goes to EXECUCAO next cycle.
  - When `ptr` reaches `PROFUNDIDADE` without `carga_fim`: `carga_pronto`=0, `erro`=1, and the state stays in CARGA until `recarga` or reset.
- **EXECUCAO**
  - `cpu_habilita`=1, `mem_escrita`=0, `mem_endereco`=`cpu_endereco[AW-1:0]`.
  - `cpu_instrucao`=`mem_instrucao` when the address is in range [`END_INICIAL`, `END_INICIAL`+`palavras`).
  - An out-of-range fetch returns 32'd0 (NOP); if `cpu_busca`=1, `erro` is set.
  - When `cpu_busca`=1 and `cpu_instrucao[31:27]`==`OPC_HALT` (5'd18): the state goes to PARADO next cycle.
- **PARADO**
  - `cpu_habilita`=0, `parado`=1, `cpu_instrucao`=0, memory idle.
- **`recarga`** (any state): next state CARGA, `ptr` ← `END_INICIAL`, `erro` ← 0, `parado` ← 0.
  - In CARGA with a simultaneous accepted word: `recarga` wins and the word is not written (`carga_pronto` is forced 0 that cycle).
  - In EXECUCAO with a simultaneous HALT fetch: `recarga` wins.
- `cpu_endereco` bits [31:AW] are ignored. All counters are AW bits; `ptr` never exceeds `PROFUNDIDADE`.
- Memory contents are never cleared by the arbiter.

## Timing
- Reset values, effective on the first edge with `reset`=1:
  - state CARGA, `ptr`=`END_INICIAL`, `palavras`=0, `erro`=0, `parado`=0.
  - Derived outputs: `cpu_habilita`=0, `carga_pronto`=1, `mem_escrita`=0.
- Reset in the middle of a load or during execution: same values; a word presented in the reset cycle is not written.
- Load handshake: a word transfers on the rising edge where `carga_valido`&`carga_pronto`; one word per cycle sustained.
- Loader → CPU: the last word is written at edge N; `cpu_habilita`=1 from cycle N+1.
- Fetch: combinational from `cpu_endereco` to `cpu_instrucao`, zero cycle latency.
- HALT fetched in cycle N: `cpu_habilita`=0 and `parado`=1 in cycle N+1.
- All outputs are decoded from registered state plus inputs; there are no output registers.

## Structure
- Shared package `pkg_processador`:
  - state enum `estado_arbitro_t` {CARGA, EXECUCAO, PARADO}.
  - `OPC_HALT`=5'd18, `OPC_NOP_INSTR`=32'd0.
  - `LARGURA_OPCODE`=5 and opcode field position [31:27].
- One natural sub-module, `contador_carga`: `ptr` with load/increment/saturate at `PROFUNDIDADE` and a full flag.

## Test plan
- Reset, then load 3 words (0x80000019, 0xC8400000, 0x90000000 with `carga_fim`) → memory addresses 1–3 written, `palavras`=3, `cpu_habilita`=1 in the cycle after the 3rd accept.
- In EXECUCAO: fetch address 2 → `cpu_instrucao`=0xC8400000; fetch address 3 (opcode 18) with `cpu_busca` → `parado`=1 and `cpu_habilita`=0 the next cycle.
- Fetch address 7 with `palavras`=3 → `cpu_instrucao`=0, `erro`=1; `recarga` clears `erro`.
- Stream 41 words without `carga_fim` → `carga_pronto`=0 after 40 accepts (addresses 1–40), `erro`=1, state stays CARGA, no further writes.
- `recarga` asserted together with a valid loader word, and `reset` asserted mid-load after 2 words → the word is not written, `ptr`=1, restarting the load overwrites from address 1.
- Back-to-back loads (HALT → `recarga` → new 5-word program) → `palavras`=5 and fetches return the new contents.
